// File: rtl/pick_trail_renderer.sv
// Rotating ball-trail sprite: a shared rotation datapath fills a
// double-buffered ball table once per frame (one ball per cycle), and a
// three-register pixel pipeline hit-tests the front table.
module pick_trail_renderer #(
  parameter int NUM_BALLS = 10,
  parameter int SPACING   = 10,
  parameter int BALL_R2   = 121,
  parameter int COORD_W   = 10,
  parameter int TRIG_W    = 10,
  parameter int FRAC      = 8
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          frame_start,
  input  logic [COORD_W-1:0]            centerX,
  input  logic [COORD_W-1:0]            centerY,
  input  logic [COORD_W-1:0]            radius,
  input  logic signed [TRIG_W-1:0]      cos_val,
  input  logic signed [TRIG_W-1:0]      sin_val,
  input  logic [NUM_BALLS-1:0]          ball_en,
  input  logic [COORD_W-1:0]            drawX,
  input  logic [COORD_W-1:0]            drawY,
  output logic                          show_pick,
  output logic [$clog2(NUM_BALLS)-1:0]  hit_index,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_BALLS);
  localparam int RW    = COORD_W + 1;          // signed per-ball radius
  localparam int PW    = RW + TRIG_W;          // full rotation product
  localparam int XW    = PW + 1;               // centre + offset, never wraps
  localparam int DW    = COORD_W + 1;          // signed pixel delta
  localparam int SW    = 2 * DW + 1;           // dx^2 + dy^2 at full width
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_BALLS - 1);
  localparam logic signed [XW-1:0] CMAX     = XW'((2 ** COORD_W) - 1);
  localparam logic signed [SW-1:0] R2_S     = SW'(BALL_R2);

  typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 latch_c;
  logic                 sel_q;                 // index of the front table
  logic                 back_c;

  logic [COORD_W-1:0]       cx_q, cy_q, rad_q;
  logic signed [TRIG_W-1:0] cos_q, sin_q;
  logic [NUM_BALLS-1:0]     en_q;

  logic [COORD_W-1:0]   tx_q [2][NUM_BALLS];
  logic [COORD_W-1:0]   ty_q [2][NUM_BALLS];
  logic [NUM_BALLS-1:0] tv_q [2];

  logic [RW-1:0]        step_c;
  logic signed [RW-1:0] r_c;
  logic signed [PW-1:0] px_c, py_c;
  logic signed [XW-1:0] x_c, y_c;
  logic                 ok_c;

  logic signed [DW-1:0] dx_p1_q [NUM_BALLS];
  logic signed [DW-1:0] dy_p1_q [NUM_BALLS];
  logic [NUM_BALLS-1:0] vld_p1_q;
  logic signed [SW-1:0] d2_c;
  logic [NUM_BALLS-1:0] hit_c, hit_p2_q;
  logic [IDX_W-1:0]     enc_c;
  logic                 show_q;
  logic [IDX_W-1:0]     hidx_q;

  assign back_c     = ~sel_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == SWAP);
  assign show_pick  = show_q;
  assign hit_index  = hidx_q;

  // Frame sequencer: latch on start, one ball per cycle, then flip tables.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          latch_c = 1'b1;
          idx_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = SWAP;
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, front select and valid bits; reset invalidates both tables.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= 1'b0;
      tv_q[0] <= '0;
      tv_q[1] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == SWAP) sel_q <= back_c;
      if (state_q == COMPUTE) tv_q[back_c][idx_q] <= ok_c;
    end
  end

  // Frame parameters held steady for the whole computation.
  always_ff @(posedge CLK) begin
    if (latch_c) begin
      cx_q  <= centerX;
      cy_q  <= centerY;
      rad_q <= radius;
      cos_q <= cos_val;
      sin_q <= sin_val;
      en_q  <= ball_en;
    end
  end

  // Rotation of ball idx; range-checked wide so off-screen balls never wrap.
  always_comb begin
    step_c = RW'(idx_q * SPACING);
    r_c    = $signed({1'b0, rad_q}) - $signed(step_c);
    px_c   = (PW'(r_c) * PW'(cos_q)) >>> FRAC;
    py_c   = (PW'(r_c) * PW'(sin_q)) >>> FRAC;
    x_c    = XW'($signed({1'b0, cx_q})) + XW'(px_c);
    y_c    = XW'($signed({1'b0, cy_q})) - XW'(py_c);
    ok_c   = en_q[idx_q] && !r_c[RW-1] &&
             !x_c[XW-1] && (x_c <= CMAX) &&
             !y_c[XW-1] && (y_c <= CMAX);
  end

  // Back-table coordinates, written as each ball is computed.
  always_ff @(posedge CLK) begin
    if (state_q == COMPUTE) begin
      tx_q[back_c][idx_q] <= x_c[COORD_W-1:0];
      ty_q[back_c][idx_q] <= y_c[COORD_W-1:0];
    end
  end

  // ---- stage p1: pixel deltas against the front table ----
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      vld_p1_q <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_p1_q[i] <= '0;
        dy_p1_q[i] <= '0;
      end
    end else begin
      vld_p1_q <= tv_q[sel_q];
      for (int i = 0; i < NUM_BALLS; i++) begin
        dx_p1_q[i] <= $signed({1'b0, drawX}) - $signed({1'b0, tx_q[sel_q][i]});
        dy_p1_q[i] <= $signed({1'b0, drawY}) - $signed({1'b0, ty_q[sel_q][i]});
      end
    end
  end

  // Inclusive distance test per ball at full precision.
  always_comb begin
    hit_c = '0;
    d2_c  = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      d2_c     = SW'(dx_p1_q[i]) * SW'(dx_p1_q[i]) +
                 SW'(dy_p1_q[i]) * SW'(dy_p1_q[i]);
      hit_c[i] = vld_p1_q[i] && (d2_c <= R2_S);
    end
  end

  // ---- stage p2: per-ball hit flags ----
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) hit_p2_q <= '0;
    else       hit_p2_q <= hit_c;
  end

  // Lowest-index hit wins; zero when nothing is hit.
  always_comb begin
    enc_c = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit_p2_q[i]) enc_c = IDX_W'(i);
    end
  end

  // ---- output stage: registered show_pick / hit_index ----
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      show_q <= 1'b0;
      hidx_q <= '0;
    end else begin
      show_q <= |hit_p2_q;
      hidx_q <= enc_c;
    end
  end

endmodule
